// File: rtl/alu_pkg.sv
// Shared op codes and FSM states for the execution-stage ALU.
// Also imported by the ALU decoder so both sides agree on the encoding.
package alu_pkg;

   typedef enum logic [3:0] {
      OP_ADD     = 4'b0000,
      OP_SUB     = 4'b0001,
      OP_MULT    = 4'b0010,
      OP_DIV     = 4'b0011,
      OP_SL      = 4'b0100,
      OP_SR      = 4'b0101,
      OP_AND     = 4'b0110,
      OP_OR      = 4'b0111,
      OP_XOR     = 4'b1000,
      OP_NOR     = 4'b1001,
      OP_JR      = 4'b1010,
      OP_NAND    = 4'b1011,
      OP_NOT     = 4'b1100,
      OP_SLT     = 4'b1101,
      OP_SGT     = 4'b1110,
      OP_ILLEGAL = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } alu_state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned datapath: shift-add multiply and restoring divide.
// lo_o/hi_o carry the value the final step produces, valid while done_o.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mul_start_i,
   input  logic             div_start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             done_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o
);

   localparam int CW = $clog2(WIDTH);

   logic                 busy_q;
   logic                 is_div_q;
   logic [CW-1:0]        cnt_q;
   logic [WIDTH-1:0]     opnd_q;
   logic [2*WIDTH-1:0]   p_q;
   logic [2*WIDTH-1:0]   p_d;
   logic [WIDTH:0]       add_sum;
   logic [WIDTH:0]       rem_try;

   // p_q holds {acc, multiplier} for mult and {remainder, dividend/quotient} for div
   always_comb begin
      add_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]}
              + (p_q[0] ? {1'b0, opnd_q} : '0);
      rem_try = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]}
              - {1'b0, opnd_q};
      p_d = {add_sum, p_q[WIDTH-1:1]};
      if (is_div_q) begin
         if (rem_try[WIDTH]) begin
            p_d = {p_q[2*WIDTH-2:0], 1'b0};
         end else begin
            p_d = {rem_try[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
         end
      end
   end

   assign done_o = busy_q && (cnt_q == CW'(WIDTH-1));
   assign lo_o   = p_d[WIDTH-1:0];
   assign hi_o   = p_d[2*WIDTH-1:WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q   <= 1'b0;
         is_div_q <= 1'b0;
         cnt_q    <= '0;
         opnd_q   <= '0;
         p_q      <= '0;
      end else if (mul_start_i) begin
         busy_q   <= 1'b1;
         is_div_q <= 1'b0;
         cnt_q    <= '0;
         opnd_q   <= a_i;
         p_q      <= {{WIDTH{1'b0}}, b_i};
      end else if (div_start_i) begin
         busy_q   <= 1'b1;
         is_div_q <= 1'b1;
         cnt_q    <= '0;
         opnd_q   <= b_i;
         p_q      <= {{WIDTH{1'b0}}, a_i};
      end else if (busy_q) begin
         p_q   <= p_d;
         cnt_q <= cnt_q + 1'b1;
         if (done_o) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_multicycle.sv
// Multicycle execution ALU: single-cycle ops plus iterative mult/div.
// Define ALU_FAST_MUL_EN to make mult a single-cycle combinational op.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       alucontrol,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] hi,
   output logic             zero,
   output logic             dbz,
   output logic             illegal
);

   alu_state_e       state_q;
   logic             ready_q;
   logic             valid_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] hi_q;
   logic             zero_q;
   logic             dbz_q;
   logic             ill_q;

   alu_op_e          op;
   logic [WIDTH-1:0] sc_res;
   logic [WIDTH-1:0] sc_hi;
   logic             sc_dbz;
   logic             sc_ill;
   logic             go_mul;
   logic             go_div;
   logic             md_done;
   logic [WIDTH-1:0] md_lo;
   logic [WIDTH-1:0] md_hi;

   assign op = alu_op_e'(alucontrol);

`ifdef ALU_FAST_MUL_EN
   logic [2*WIDTH-1:0] prod;
   assign prod   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
   assign go_mul = 1'b0;
`else
   assign go_mul = start && (state_q == S_IDLE) && (op == OP_MULT);
`endif
   assign go_div = start && (state_q == S_IDLE) && (op == OP_DIV)
                 && (b != '0);

   always_comb begin
      sc_res = '0;
      sc_hi  = '0;
      sc_dbz = 1'b0;
      sc_ill = 1'b0;
      unique case (op)
         OP_ADD:  sc_res = a + b;
         OP_SUB:  sc_res = a - b;
         OP_MULT: begin
`ifdef ALU_FAST_MUL_EN
            sc_res = prod[WIDTH-1:0];
            sc_hi  = prod[2*WIDTH-1:WIDTH];
`endif
         end
         // only reached with b==0; nonzero divisors go iterative
         OP_DIV: begin
            sc_res = '1;
            sc_hi  = a;
            sc_dbz = 1'b1;
         end
         OP_SL:   sc_res = a << b[SHW-1:0];
         OP_SR:   sc_res = a >> b[SHW-1:0];
         OP_AND:  sc_res = a & b;
         OP_OR:   sc_res = a | b;
         OP_XOR:  sc_res = a ^ b;
         OP_NOR:  sc_res = ~(a | b);
         OP_JR:   sc_res = a;
         OP_NAND: sc_res = ~(a & b);
         OP_NOT:  sc_res = ~a;
         OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SGT:  sc_res = {{(WIDTH-1){1'b0}}, $signed(a) > $signed(b)};
         OP_ILLEGAL: sc_ill = 1'b1;
      endcase
   end

   alu_muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk         (clk),
      .rst_n       (rst_n),
      .mul_start_i (go_mul),
      .div_start_i (go_div),
      .a_i         (a),
      .b_i         (b),
      .done_o      (md_done),
      .lo_o        (md_lo),
      .hi_o        (md_hi)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
         res_q   <= '0;
         hi_q    <= '0;
         zero_q  <= 1'b0;
         dbz_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  ready_q <= 1'b0;
                  if (go_mul) begin
                     state_q <= S_MUL;
                  end else if (go_div) begin
                     state_q <= S_DIV;
                  end else begin
                     state_q <= S_DONE;
                     valid_q <= 1'b1;
                     res_q   <= sc_res;
                     hi_q    <= sc_hi;
                     zero_q  <= (sc_res == '0);
                     dbz_q   <= sc_dbz;
                     ill_q   <= sc_ill;
                  end
               end
            end
            S_MUL, S_DIV: begin
               if (md_done) begin
                  state_q <= S_DONE;
                  valid_q <= 1'b1;
                  res_q   <= md_lo;
                  hi_q    <= md_hi;
                  zero_q  <= (md_lo == '0);
                  dbz_q   <= 1'b0;
                  ill_q   <= 1'b0;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign ready   = ready_q;
   assign valid   = valid_q;
   assign result  = res_q;
   assign hi      = hi_q;
   assign zero    = zero_q;
   assign dbz     = dbz_q;
   assign illegal = ill_q;

endmodule
